// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared types and constants for the UART program loader
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ld_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    localparam int UPG_ADR_W   = 15;
    localparam int UPG_DAT_W   = 32;
    localparam int UPG_TGT_BIT = 14;

    // Little-endian lane insert: lane 0 is bits 7:0.
    function automatic logic [UPG_DAT_W-1:0] put_lane(input logic [UPG_DAT_W-1:0] word,
                                                      input logic [1:0]           lane,
                                                      input logic [7:0]           b);
        logic [UPG_DAT_W-1:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - upgrade write port toward program ROM / data RAM
interface uart_prog_loader_if;
    import uart_prog_loader_pkg::*;

    logic                 upg_rst_o;
    logic                 upg_wen_o;
    logic [UPG_ADR_W-1:0] upg_adr_o;
    logic [UPG_DAT_W-1:0] upg_dat_o;
    logic                 upg_done_o;

    modport master (
        output upg_rst_o,
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input upg_rst_o,
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o
    );

endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with input synchronizer
module uart_byte_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int                BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF   = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL   = BAUD_W'(CLKS_PER_BIT - 1);

    logic              rx_meta, rx_sync;
    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              valid_d, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            state_q      <= R_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_o <= valid_d;
            frame_err_o  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!rx_sync) begin
                    state_d = R_START;
                    baud_d  = HALF;
                end
            end
            R_START: begin
                // Mid-start-bit re-check filters short low glitches.
                if (baud_q == '0) begin
                    if (rx_sync) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d = R_DATA;
                        baud_d  = FULL;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            R_DATA: begin
                if (baud_q == '0) begin
                    shift_d = {rx_sync, shift_q[7:1]};
                    baud_d  = FULL;
                    if (bit_q == 3'd7) state_d = R_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            R_STOP: begin
                if (baud_q == '0) begin
                    state_d = R_IDLE;
                    if (rx_sync) valid_d = 1'b1;
                    else         ferr_d  = 1'b1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_o = shift_q;
    assign busy_o = (state_q != R_IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program image loader driving the upg_* write port
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TOTAL_WORDS  = 32768,
    parameter int IDLE_BITS    = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_pg,
    input  logic               rx,
    uart_prog_loader_if.master upg,
    output logic               frame_err_o
);

    localparam int                IDLE_CLKS = IDLE_BITS * CLKS_PER_BIT;
    localparam int                IDLE_W    = $clog2(IDLE_CLKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);
    localparam logic [16:0]       TOTAL     = 17'(TOTAL_WORDS);

    logic st_meta, st_sync, st_prev, start_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_meta <= 1'b0;
            st_sync <= 1'b0;
            st_prev <= 1'b0;
        end else begin
            st_meta <= start_pg;
            st_sync <= st_meta;
            st_prev <= st_sync;
        end
    end

    assign start_req = st_sync & ~st_prev;

    logic [7:0] rx_byte;
    logic       byte_valid, rx_busy;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n        (rst),
        .rx           (rx),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err_o),
        .busy_o       (rx_busy)
    );

    ld_state_t            state_q, state_d;
    logic [15:0]          word_cnt;
    logic [1:0]           byte_cnt;
    logic [UPG_DAT_W-1:0] word_buf;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 wen_q;
    logic [UPG_ADR_W-1:0] adr_q;
    logic [UPG_DAT_W-1:0] dat_q;
    logic                 timeout;

    // A byte arriving in the expiry cycle beats the timeout.
    assign timeout = (idle_cnt == IDLE_LAST) && (word_cnt != 16'd0) && !byte_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_req) state_d = LOAD;
            LOAD: begin
                if ({1'b0, word_cnt} >= TOTAL) state_d = DONE;
                else if (timeout)              state_d = DONE;
            end
            DONE: if (start_req) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            idle_cnt <= '0;
            wen_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
        end else begin
            wen_q <= 1'b0;
            if (state_q != LOAD && state_d == LOAD) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (state_q == LOAD) begin
                if (rx_busy || byte_valid)   idle_cnt <= '0;
                else if (idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 1'b1;
                if (byte_valid) begin
                    word_buf <= put_lane(word_buf, byte_cnt, rx_byte);
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wen_q    <= 1'b1;
                        adr_q    <= {word_cnt[UPG_TGT_BIT], word_cnt[UPG_TGT_BIT-1:0]};
                        dat_q    <= put_lane(word_buf, 2'd3, rx_byte);
                        word_cnt <= word_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign upg.upg_rst_o  = (state_q != LOAD);
    assign upg.upg_done_o = (state_q == DONE);
    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        logic [14:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, st0, st1, rx0, rx1, ferr0, ferr1;

    uart_prog_loader_if if0 ();
    uart_prog_loader_if if1 ();

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .TOTAL_WORDS(4), .IDLE_BITS(20)) dut (
        .clk(clk), .rst(rst0), .start_pg(st0), .rx(rx0), .upg(if0), .frame_err_o(ferr0)
    );

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .TOTAL_WORDS(32768), .IDLE_BITS(20)) dut2 (
        .clk(clk), .rst(rst1), .start_pg(st1), .rx(rx1), .upg(if1), .frame_err_o(ferr1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Byte-level model: 0 = idle, 1 = loading, 2 = done
    wr_t         exp0[$];
    wr_t         exp1[$];
    int          m_state[2];
    int          m_word[2];
    int          m_lane[2];
    logic [31:0] m_buf[2];
    int          m_total[2] = '{4, 32768};

    task automatic push_exp(input int s, input logic [14:0] a, input logic [31:0] d);
        wr_t e;
        e.adr = a;
        e.dat = d;
        if (s == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic model_reset(input int s);
        m_state[s] = 0; m_word[s] = 0; m_lane[s] = 0; m_buf[s] = 0;
        if (s == 0) exp0.delete();
        else        exp1.delete();
    endtask

    task automatic model_start(input int s);
        if (m_state[s] != 1) begin
            m_state[s] = 1; m_word[s] = 0; m_lane[s] = 0; m_buf[s] = 0;
        end
    endtask

    task automatic model_timeout(input int s);
        if (m_state[s] == 1 && m_word[s] >= 1) m_state[s] = 2;
    endtask

    task automatic model_byte(input int s, input logic [7:0] b, input bit ok);
        if (!ok || m_state[s] != 1) return;
        m_buf[s][8*m_lane[s] +: 8] = b;
        m_lane[s]++;
        if (m_lane[s] == 4) begin
            push_exp(s, 15'(m_word[s]), m_buf[s]);
            m_word[s]++;
            m_lane[s] = 0;
            m_buf[s]  = 0;
            if (m_word[s] == m_total[s]) m_state[s] = 2;
        end
    endtask

    // Compare process state
    int   cyc = 0;
    int   bv_cyc[2], strobe_cyc[2], done_rise_cyc[2], nstrobe[2], nferr[2];
    logic done_prev[2] = '{1'b0, 1'b0};

    task automatic cmp_port(input int s, input logic wen, input logic [14:0] adr,
                            input logic [31:0] dat, input logic done, input logic rsto,
                            input logic ferr, input logic bv);
        wr_t e;
        if (bv) bv_cyc[s] = cyc;
        if (wen) begin
            nstrobe[s]++;
            strobe_cyc[s] = cyc;
            if ((s == 0 && exp0.size() == 0) || (s == 1 && exp1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL strobe%0d_unexpected: got adr=0x%h dat=0x%h, required no strobe", s, adr, dat);
            end else begin
                if (s == 0) e = exp0.pop_front();
                else        e = exp1.pop_front();
                chk($sformatf("strobe%0d_adr", s), adr, e.adr);
                chk($sformatf("strobe%0d_dat", s), dat, e.dat);
                chk($sformatf("strobe%0d_latency", s), cyc - bv_cyc[s], 1);
            end
        end
        if (done && !done_prev[s]) done_rise_cyc[s] = cyc;
        done_prev[s] = done;
        if (ferr) nferr[s]++;
        if (done) chk($sformatf("done%0d_core_released", s), rsto, 1);
    endtask

    always @(negedge clk) begin
        cyc++;
        cmp_port(0, if0.upg_wen_o, if0.upg_adr_o, if0.upg_dat_o, if0.upg_done_o,
                 if0.upg_rst_o, ferr0, dut.u_rx.byte_valid_o);
        cmp_port(1, if1.upg_wen_o, if1.upg_adr_o, if1.upg_dat_o, if1.upg_done_o,
                 if1.upg_rst_o, ferr1, dut2.u_rx.byte_valid_o);
    end

    // Stimulus helpers
    task automatic set_rx(input int s, input logic v);
        if (s == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic drive_bit(input int s, input logic v);
        set_rx(s, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input bit ok = 1'b1);
        model_byte(s, b, ok);
        drive_bit(s, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(s, b[i]);
        drive_bit(s, ok);
        drive_bit(s, 1'b1);
    endtask

    task automatic send_word(input int s, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(s, w[8*i +: 8]);
    endtask

    task automatic pulse_start(input int s);
        if (s == 0) st0 = 1'b1; else st1 = 1'b1;
        repeat (4) @(negedge clk);
        if (s == 0) st0 = 1'b0; else st1 = 1'b0;
        model_start(s);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset0(input string tag);
        chk({tag, "_upg_rst"},  if0.upg_rst_o, 1);
        chk({tag, "_upg_wen"},  if0.upg_wen_o, 0);
        chk({tag, "_upg_adr"},  if0.upg_adr_o, 0);
        chk({tag, "_upg_dat"},  if0.upg_dat_o, 0);
        chk({tag, "_upg_done"}, if0.upg_done_o, 0);
        chk({tag, "_frame_err"}, ferr0, 0);
    endtask

    int          n0, f0;
    logic [14:0] adr_v;

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; st0 = 1'b0; st1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_reset0("in_reset");
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset0("after_reset");

        // 1: bytes are ignored before any start request
        send_byte(0, 8'h55);
        repeat (4) @(negedge clk);
        chk("idle_no_strobe", nstrobe[0], 0);
        chk("idle_core_runs", if0.upg_rst_o, 1);

        // 2: single word assembly, little-endian
        pulse_start(0);
        chk("load_core_held", if0.upg_rst_o, 0);
        chk("load_not_done", if0.upg_done_o, 0);
        send_byte(0, 8'h78); send_byte(0, 8'h56); send_byte(0, 8'h34); send_byte(0, 8'h12);
        repeat (4) @(negedge clk);
        chk("word1_count", nstrobe[0], 1);
        chk("word1_adr_hold", if0.upg_adr_o, 15'h0000);
        chk("word1_dat_hold", if0.upg_dat_o, 32'h12345678);

        // 3: full image of TOTAL_WORDS words ends the load
        rst0 = 1'b0; model_reset(0);
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(0);
        n0 = nstrobe[0];
        for (int w = 1; w <= 4; w++) send_word(0, 32'(w));
        repeat (4) @(negedge clk);
        chk("image_strobes", nstrobe[0] - n0, 4);
        chk("image_done", if0.upg_done_o, 1);
        chk("image_core_released", if0.upg_rst_o, 1);
        chk("done_one_after_last_strobe", done_rise_cyc[0] - strobe_cyc[0], 1);
        chk("image_last_adr", if0.upg_adr_o, 15'h0003);
        chk("image_last_dat", if0.upg_dat_o, 32'h00000004);
        send_word(0, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        chk("done_ignores_bytes", nstrobe[0] - n0, 4);

        // 5: idle timeout drops a partial word; re-programming restarts at 0
        pulse_start(0);
        chk("reprog_done_clear", if0.upg_done_o, 0);
        n0 = nstrobe[0];
        send_word(0, 32'hDDCCBBAA);
        send_byte(0, 8'hE1); send_byte(0, 8'hE2);
        repeat (60) @(negedge clk);
        chk("timeout_not_yet", if0.upg_done_o, 0);
        repeat (40) @(negedge clk);
        model_timeout(0);
        chk("timeout_done", if0.upg_done_o, 1);
        chk("timeout_partial_dropped", nstrobe[0] - n0, 1);
        pulse_start(0);
        chk("restart_done_clear", if0.upg_done_o, 0);
        send_word(0, 32'h04030201);
        repeat (4) @(negedge clk);
        chk("restart_adr", if0.upg_adr_o, 15'h0000);
        chk("restart_dat", if0.upg_dat_o, 32'h04030201);

        // 6: frame error, glitch rejection, then asynchronous reset mid-load
        f0 = nferr[0];
        n0 = nstrobe[0];
        send_byte(0, 8'hA5, 1'b0);
        chk("frame_err_one_pulse", nferr[0] - f0, 1);
        rx0 = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_no_frame_err", nferr[0] - f0, 1);
        send_word(0, 32'hCAFEF00D);
        repeat (4) @(negedge clk);
        chk("after_err_strobes", nstrobe[0] - n0, 1);
        chk("after_err_adr", if0.upg_adr_o, 15'h0001);
        chk("after_err_dat", if0.upg_dat_o, 32'hCAFEF00D);
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst0 = 1'b0;
        model_reset(0);
        #1 check_reset0("async_reset");
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        n0 = nstrobe[0];
        repeat (30) @(negedge clk);
        chk("reset_no_write", nstrobe[0] - n0, 0);

        // 4: ROM/RAM boundary on the full-size instance
        pulse_start(1);
        force dut2.word_cnt = 16'd16383;
        @(negedge clk);
        release dut2.word_cnt;
        m_word[1] = 16383;
        send_word(1, 32'h44332211);
        repeat (4) @(negedge clk);
        chk("rom_last_adr", if1.upg_adr_o, 15'h3FFF);
        send_word(1, 32'h88776655);
        repeat (4) @(negedge clk);
        adr_v = if1.upg_adr_o;
        chk("ram_first_adr", adr_v, 15'h4000);
        chk("ram_target_bit", adr_v[UPG_TGT_BIT], 1);
        chk("ram_first_dat", if1.upg_dat_o, 32'h88776655);
        chk("boundary_strobes", nstrobe[1], 2);

        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream of the program ROM and data memory upg_* ports.
- Receives a program image over UART rx and assembles bytes into 32-bit little-endian words.
- Issues one-cycle write strobes with a word address; address bit 14 selects the target: 0 = instruction ROM, 1 = data RAM.
- While a load is in progress it holds the CPU core in reset and asserts upg_done_o when the image is complete.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (8N1); must be >= 4.
- TOTAL_WORDS, 32768, word writes that end a load (16384 ROM words followed by 16384 RAM words).
- IDLE_BITS, 40, bit-times of rx silence after at least one full word that also ends a load.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start_pg  in  1  program-mode request (button level, asynchronous).
- rx  in  1  UART receive line (asynchronous, idle high).
- upg_rst_o  out  1  1 = loader not loading (core may run); 0 = load in progress.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  15  word address; bit 14 = target select, bits 13:0 = word index.
- upg_dat_o  out  32  write data, valid while upg_wen_o = 1.
- upg_done_o  out  1  image complete; sticky until the next load or reset.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Loader state = IDLE; receiver state = R_IDLE; all counters cleared.
  - Outputs: upg_rst_o = 1, upg_wen_o = 0, upg_adr_o = 0, upg_dat_o = 0, upg_done_o = 0, frame_err_o = 0.
  - Reset asserted mid-frame or mid-word abandons the load; no write is issued.
- Input conditioning:
  - rx and start_pg each pass through a 2-FF synchronizer.
  - start_pg is rising-edge detected on the synchronized signal, giving a one-cycle start_req.
- Receiver FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE.
  - R_IDLE: on synchronized rx = 0, go to R_START and load the bit counter.
  - R_START: at CLKS_PER_BIT/2 re-sample rx. If rx = 1 (glitch), return to R_IDLE. Otherwise go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT, LSB first, 8 bits.
  - R_STOP: sample once. rx = 1 gives byte_valid for one cycle. rx = 0 gives frame_err_o for one cycle, the byte is dropped, and the byte count does not advance.
  - The receiver runs in every loader state, but bytes are consumed only in LOAD.
- Loader FSM: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start_req. Entering LOAD clears word_cnt, byte_cnt and the idle timer, and sets upg_done_o = 0.
  - In LOAD, each byte_valid places the byte into lane byte_cnt (0 = bits 7:0 ... 3 = bits 31:24), then byte_cnt++.
  - When byte_cnt wraps from 3 to 0, the next cycle carries exactly one write: upg_wen_o = 1, upg_adr_o = word_cnt[14:0], upg_dat_o = the assembled word. word_cnt then increments.
  - Byte-to-strobe latency is 1 clk after byte_valid.
  - LOAD -> DONE in the cycle after the write that brings word_cnt to TOTAL_WORDS. word_cnt is 16 bits wide, so TOTAL_WORDS = 32768 does not wrap.
  - LOAD -> DONE when word_cnt >= 1 and no receiver activity (state R_IDLE) for IDLE_BITS*CLKS_PER_BIT clks. Any pending partial word (byte_cnt != 0) is discarded with no write.
  - The idle timer resets on every start-bit detection.
  - In DONE: upg_done_o = 1, bytes are ignored, and start_req returns to LOAD (re-programming).
  - start_req while in LOAD is ignored.
- Output decode:
  - upg_rst_o = 0 exactly while in LOAD; 1 in IDLE and DONE.
  - upg_adr_o and upg_dat_o hold their last values between strobes.
- Simultaneous events:
  - A timeout and a byte_valid in the same cycle: the byte wins and the timer restarts.
  - A frame error has no effect on word_cnt.

Decomposition:
- Shared package:
  - Loader state enum (IDLE/LOAD/DONE).
  - Receiver state enum (R_IDLE/R_START/R_DATA/R_STOP).
  - Constants UPG_ADR_W = 15, UPG_DAT_W = 32, UPG_TGT_BIT = 14.
- One natural sub-module: uart_byte_rx.
  - Contains the synchronizer, the receiver FSM and the bit/baud counters.
  - Outputs byte_o[7:0], byte_valid_o, frame_err_o, busy_o.
  - The loader FSM, byte assembly and idle timer stay in uart_prog_loader.

Test Plan (CLKS_PER_BIT = 4, TOTAL_WORDS = 4, IDLE_BITS = 20 unless noted):
1. Release reset with no start_pg -> all outputs at reset values; send byte 0x55 -> no upg_wen_o, upg_rst_o stays 1.
2. start_pg pulse, then bytes 78 56 34 12 -> upg_rst_o = 0; a single upg_wen_o with upg_adr_o = 0x0000, upg_dat_o = 0x12345678, 1 clk after the 4th stop bit.
3. Send 16 bytes (words 0x00000001..0x00000004) -> four strobes at addresses 0..3; upg_done_o = 1 and upg_rst_o = 1 the cycle after the 4th strobe; a further byte causes no strobe.
4. TOTAL_WORDS = 32768, force word_cnt = 16383, send one word -> upg_adr_o = 0x3FFF; next word -> upg_adr_o = 0x4000 (RAM target).
5. Send 1 word plus 2 bytes, then silence -> exactly 1 strobe; after 80 clks upg_done_o = 1 with no strobe for the partial word; another start_pg -> upg_done_o = 0, next word written at address 0.
6. Send a byte with stop bit 0 -> frame_err_o pulse, byte_cnt unchanged; a 1-clk rx low glitch causes no byte; assert rst after 2 bytes -> all outputs return to reset values immediately.
